// File: rtl/csa_pkg.sv
// Shared definitions for the carry-skip adder slice: adder width and the
// operand sequencer state encoding.
package csa_pkg;

    // Width of the external carry-skip adder and of every operand byte.
    localparam int CSA_WIDTH = 8;

    // Operand sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ADD    = 2'd2,
        OUT    = 2'd3
    } csa_state_e;

endpackage : csa_pkg

// File: rtl/csa_operand_sequencer.sv
// Operand sequencer for the 8-bit carry-skip adder. Pairs incoming bytes into
// A/B operands, drives them with a chained carry-in into the external adder,
// registers the adder result and hands it downstream one byte per pair.
// Multi-byte little-endian words are added as a chain of 8-bit adds; the
// carry is passed between bytes of a word and cleared at the word boundary.
module csa_operand_sequencer
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,

    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,

    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,

    output logic             busy
);

    csa_state_e       state_q, state_d;

    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_last_q, out_last_d;

    // State register; reset drops any partial pair or pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: two byte loads, one adder cycle, then hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A: if (in_valid)  state_d = LOAD_B;
            LOAD_B: if (in_valid)  state_d = ADD;
            ADD:                   state_d = OUT;
            OUT:    if (out_ready) state_d = LOAD_A;
            default:               state_d = LOAD_A;
        endcase
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != LOAD_A);
        case (state_q)
            LOAD_A:  in_ready  = 1'b1;
            LOAD_B:  in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: operand capture, result capture, and the chain
    // carry, which only moves on the result handshake so the adder inputs
    // never change under a pending result.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_last_d  = out_last_q;
        case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    op_a_d = in_data;
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    op_b_d = in_data;
                    last_d = in_last;
                end
            end
            ADD: begin
                out_data_d  = add_sum;
                out_carry_d = add_cout;
                out_last_d  = last_q;
            end
            OUT: begin
                if (out_ready) begin
                    op_cin_d = out_last_q ? 1'b0 : out_carry_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            last_q      <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_last_q  <= out_last_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_cin    = op_cin_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_last  = out_last_q;

endmodule : csa_operand_sequencer

// File: tb/tb_csa_operand_sequencer.sv
// Bench for csa_operand_sequencer. A behavioural 8-bit adder stands in for the
// carry-skip adder; expected results are pushed to a queue as pairs are sent
// and a monitor pops and compares them on each output handshake.
module tb_csa_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    logic [8:0] add_full;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    csa_operand_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Reference adder standing in for the carry-skip adder.
    assign add_full = {1'b0, op_a} + {1'b0, op_b} + {8'b0, op_cin};
    assign add_sum  = add_full[7:0];
    assign add_cout = add_full[8];

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute runtime limit.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted result is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", {24'b0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", {24'b0, out_data}, {24'b0, e.data});
                    checkOutput("out_carry", {31'b0, out_carry}, {31'b0, e.carry});
                    checkOutput("out_last", {31'b0, out_last}, {31'b0, e.last});
                end
            end
        end
    end

    // Offer one byte and wait (bounded) for it to be accepted.
    task automatic sendByte(input logic [7:0] d, input logic l);
        bit done = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Send an A/B pair, optionally queue its expected result, and check the
    // ADD-then-OUT latency after the B byte is taken.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic last, input logic [7:0] exp_data,
                                 input logic exp_carry, input logic push);
        exp_t e;
        e.data  = exp_data;
        e.carry = exp_carry;
        e.last  = last;
        if (push) exp_q.push_back(e);
        sendByte(a, 1'b0);
        sendByte(b, last);
        @(negedge clk);
        checkOutput("valid_in_add_cycle", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("valid_in_out_cycle", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until every queued result has been handshaken.
    task automatic waitDrain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0);
        end
        if (!done) checkOutput("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        checkOutput("rst_op_a", {24'b0, op_a}, 32'd0);
        checkOutput("rst_op_b", {24'b0, op_b}, 32'd0);
        checkOutput("rst_op_cin", {31'b0, op_cin}, 32'd0);
        checkOutput("rst_out_data", {24'b0, out_data}, 32'd0);
        checkOutput("rst_out_carry", {31'b0, out_carry}, 32'd0);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single pair");
        applyStimulus(8'h3C, 8'h0F, 1'b1, 8'h4B, 1'b0, 1'b1);

        $display("[TB] overflow then fresh word");
        applyStimulus(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);

        $display("[TB] two-byte word 0x01FF + 0x0001");
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1);
        in_data  = 8'h11;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_out_data", {24'b0, out_data}, 32'h00);
            checkOutput("bp_out_carry", {31'b0, out_carry}, 32'd1);
            checkOutput("bp_out_last", {31'b0, out_last}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_busy", {31'b0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(8'h11, 8'h22, 1'b1, 8'h33, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] reset mid-word clears chain carry");
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        waitDrain();
        checkOutput("chain_cin_set", {31'b0, op_cin}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("chain_cin_cleared", {31'b0, op_cin}, 32'd0);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] reset during OUT drops result");
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h0F, 1'b1, 8'h4B, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid_drop", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready_drop", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_busy_drop", {31'b0, busy}, 32'd0);
        checkOutput("rst_out_data_drop", {24'b0, out_data}, 32'd0);
        checkOutput("rst_op_a_drop", {24'b0, op_a}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b1);
        waitDrain();

        checkOutput("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule : tb_csa_operand_sequencer
